// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel/line counters, syncs, active-video flag, line/frame pulses.
// Latency: all outputs registered; syncs and video_on decoded from next-state counts, so they align with hc/vc.
// Backpressure: none; state advances only on clk edges with pix_en=1 and holds otherwise.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       pix_en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (pix_en) begin
            if (hc_q == H_LAST) begin
                hc_d         = '0;
                line_start_d = 1'b1;
                if (vc_q == V_LAST) begin
                    vc_d          = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vc_d = vc_q + 10'd1;
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end

        // Decoding the next counts keeps the syncs aligned with the hc/vc they are presented with.
        hsync_d    = (hc_d >= HS_FIRST && hc_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vsync_d    = (vc_d >= VS_FIRST && vc_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        video_on_d = (hc_d < H_ACT) && (vc_d < V_ACT);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hc_q          <= '0;
            vc_q          <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full-size instance for line/stall/reset timing,
// reduced-geometry instance so whole frames fit in a short run.
module tb_vga_sync_gen;

    logic       clk;
    logic       clr;
    logic       pix_en;
    logic       pix_en_s;

    logic [9:0] hc, vc;
    logic       hsync, vsync, video_on, line_start, frame_start;

    logic [9:0] hc_s, vc_s;
    logic       hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s;

    int n_cmp;
    int n_err;

    vga_sync_gen dut (
        .clk         (clk),
        .clr         (clr),
        .pix_en      (pix_en),
        .hc          (hc),
        .vc          (vc),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    // Small geometry: H 8/2/3/3 (total 16, hsync 10..12), V 6/2/2/3 (total 13, vsync 8..9).
    vga_sync_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (6),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3),
        .SYNC_POL (1'b0)
    ) dut_s (
        .clk         (clk),
        .clr         (clr),
        .pix_en      (pix_en_s),
        .hc          (hc_s),
        .vc          (vc_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .video_on    (video_on_s),
        .line_start  (line_start_s),
        .frame_start (frame_start_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic en);
        @(negedge clk);
        pix_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic step_s(input logic en);
        @(negedge clk);
        pix_en_s = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        pix_en   = 1'b0;
        pix_en_s = 1'b0;
        clr      = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if (hc !== 10'd0 || vc !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 ||
            video_on !== 1'b1 || line_start !== 1'b0 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: hc=%0d vc=%0d hs=%b vs=%b von=%b ls=%b fs=%b, want 0 0 1 1 1 0 0",
                     hc, vc, hsync, vsync, video_on, line_start, frame_start);
        end
        for (int i = 0; i < 3; i++) step(1'b1);
        n_cmp++;
        if (hc !== 10'd3) begin
            n_err++;
            $display("FAIL reset_pre_advance: hc=%0d want 3", hc);
        end
        // Assert clr in the middle of a cycle, away from any edge.
        #2;
        clr = 1'b1;
        #1;
        n_cmp++;
        if (hc !== 10'd0 || vc !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 ||
            video_on !== 1'b1 || line_start !== 1'b0 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: hc=%0d vc=%0d hs=%b vs=%b von=%b ls=%b fs=%b, want 0 0 1 1 1 0 0",
                     hc, vc, hsync, vsync, video_on, line_start, frame_start);
        end
        for (int i = 0; i < 4; i++) step(1'b1);
        n_cmp++;
        if (hc !== 10'd0 || vc !== 10'd0 || line_start !== 1'b0 || video_on !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hold_pix_en: hc=%0d vc=%0d ls=%b von=%b, want 0 0 0 1",
                     hc, vc, line_start, video_on);
        end
        @(negedge clk);
        pix_en = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic test_line_timing;
        int ls_cnt;
        ls_cnt = 0;
        do_reset();
        for (int k = 1; k <= 800; k++) begin
            step(1'b0);
            step(1'b0);
            step(1'b0);
            step(1'b1);
            if (line_start === 1'b1) ls_cnt++;
            n_cmp++;
            if (hc !== 10'(k % 800)) begin
                n_err++;
                $display("FAIL line_hc: strobe %0d hc=%0d want %0d", k, hc, k % 800);
            end
            case (k)
                639: begin
                    n_cmp++;
                    if (video_on !== 1'b1) begin
                        n_err++;
                        $display("FAIL line_von_639: got %b want 1", video_on);
                    end
                end
                640: begin
                    n_cmp++;
                    if (video_on !== 1'b0) begin
                        n_err++;
                        $display("FAIL line_von_640: got %b want 0", video_on);
                    end
                end
                655: begin
                    n_cmp++;
                    if (hsync !== 1'b1) begin
                        n_err++;
                        $display("FAIL line_hs_655: got %b want 1", hsync);
                    end
                end
                656: begin
                    n_cmp++;
                    if (hsync !== 1'b0) begin
                        n_err++;
                        $display("FAIL line_hs_656: got %b want 0", hsync);
                    end
                end
                751: begin
                    n_cmp++;
                    if (hsync !== 1'b0) begin
                        n_err++;
                        $display("FAIL line_hs_751: got %b want 0", hsync);
                    end
                end
                752: begin
                    n_cmp++;
                    if (hsync !== 1'b1) begin
                        n_err++;
                        $display("FAIL line_hs_752: got %b want 1", hsync);
                    end
                end
                799: begin
                    n_cmp++;
                    if (vc !== 10'd0 || line_start !== 1'b0) begin
                        n_err++;
                        $display("FAIL line_799: vc=%0d ls=%b want 0 0", vc, line_start);
                    end
                end
                800: begin
                    n_cmp++;
                    if (vc !== 10'd1 || line_start !== 1'b1 || frame_start !== 1'b0 || video_on !== 1'b1) begin
                        n_err++;
                        $display("FAIL line_wrap: vc=%0d ls=%b fs=%b von=%b want 1 1 0 1",
                                 vc, line_start, frame_start, video_on);
                    end
                end
                default: ;
            endcase
        end
        step(1'b0);
        n_cmp++;
        if (line_start !== 1'b0 || hc !== 10'd0 || vc !== 10'd1) begin
            n_err++;
            $display("FAIL line_pulse_width: ls=%b hc=%0d vc=%0d want 0 0 1", line_start, hc, vc);
        end
        n_cmp++;
        if (ls_cnt != 1) begin
            n_err++;
            $display("FAIL line_start_count: got %0d want 1", ls_cnt);
        end
    endtask

    task automatic test_stall;
        int bad;
        bad = 0;
        do_reset();
        for (int k = 0; k < 655; k++) step(1'b1);
        n_cmp++;
        if (hc !== 10'd655 || hsync !== 1'b1 || video_on !== 1'b0) begin
            n_err++;
            $display("FAIL stall_entry: hc=%0d hs=%b von=%b want 655 1 0", hc, hsync, video_on);
        end
        for (int k = 0; k < 37; k++) begin
            step(1'b0);
            if (hc !== 10'd655 || vc !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 ||
                video_on !== 1'b0 || line_start !== 1'b0 || frame_start !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL stall_frozen: %0d stall cycles changed, want 0", bad);
        end
        step(1'b1);
        n_cmp++;
        if (hc !== 10'd656 || hsync !== 1'b0) begin
            n_err++;
            $display("FAIL stall_resume: hc=%0d hs=%b want 656 0", hc, hsync);
        end
    endtask

    task automatic test_back_to_back;
        int ls_cnt;
        int fs_cnt;
        ls_cnt = 0;
        fs_cnt = 0;
        do_reset();
        for (int k = 0; k < 1600; k++) begin
            step(1'b1);
            if (line_start === 1'b1) ls_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
        end
        n_cmp++;
        if (hc !== 10'd0 || vc !== 10'd2 || line_start !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_position: hc=%0d vc=%0d ls=%b want 0 2 1", hc, vc, line_start);
        end
        n_cmp++;
        if (ls_cnt != 2 || fs_cnt != 0) begin
            n_err++;
            $display("FAIL b2b_pulses: line_start=%0d frame_start=%0d want 2 0", ls_cnt, fs_cnt);
        end
    endtask

    task automatic test_frame;
        int fs_cnt;
        int vs_low;
        int last_fs;
        int period;
        fs_cnt  = 0;
        vs_low  = 0;
        last_fs = 0;
        period  = 0;
        do_reset();
        for (int k = 1; k <= 416; k++) begin
            step_s(1'b1);
            if (frame_start_s === 1'b1) begin
                fs_cnt++;
                if (last_fs != 0) period = k - last_fs;
                last_fs = k;
            end
            if (k <= 208 && vsync_s === 1'b0) vs_low++;
            if (k <= 208) begin
                n_cmp++;
                if (hc_s !== 10'(k % 16) || vc_s !== 10'((k / 16) % 13)) begin
                    n_err++;
                    $display("FAIL frame_count: strobe %0d hc=%0d vc=%0d want %0d %0d",
                             k, hc_s, vc_s, k % 16, (k / 16) % 13);
                end
            end
            case (k)
                9:   begin n_cmp++; if (hsync_s !== 1'b1) begin n_err++; $display("FAIL frame_hs_9: got %b want 1", hsync_s); end end
                10:  begin n_cmp++; if (hsync_s !== 1'b0) begin n_err++; $display("FAIL frame_hs_10: got %b want 0", hsync_s); end end
                87:  begin n_cmp++; if (video_on_s !== 1'b1) begin n_err++; $display("FAIL frame_von_87: got %b want 1", video_on_s); end end
                88:  begin n_cmp++; if (video_on_s !== 1'b0) begin n_err++; $display("FAIL frame_von_88: got %b want 0", video_on_s); end end
                96:  begin n_cmp++; if (video_on_s !== 1'b0) begin n_err++; $display("FAIL frame_von_96: got %b want 0", video_on_s); end end
                127: begin n_cmp++; if (vsync_s !== 1'b1) begin n_err++; $display("FAIL frame_vs_127: got %b want 1", vsync_s); end end
                128: begin n_cmp++; if (vsync_s !== 1'b0) begin n_err++; $display("FAIL frame_vs_128: got %b want 0", vsync_s); end end
                159: begin n_cmp++; if (vsync_s !== 1'b0) begin n_err++; $display("FAIL frame_vs_159: got %b want 0", vsync_s); end end
                160: begin n_cmp++; if (vsync_s !== 1'b1) begin n_err++; $display("FAIL frame_vs_160: got %b want 1", vsync_s); end end
                207: begin
                    n_cmp++;
                    if (hc_s !== 10'd15 || vc_s !== 10'd12 || frame_start_s !== 1'b0) begin
                        n_err++;
                        $display("FAIL frame_last: hc=%0d vc=%0d fs=%b want 15 12 0", hc_s, vc_s, frame_start_s);
                    end
                end
                208: begin
                    n_cmp++;
                    if (frame_start_s !== 1'b1 || line_start_s !== 1'b1 || video_on_s !== 1'b1) begin
                        n_err++;
                        $display("FAIL frame_wrap: fs=%b ls=%b von=%b want 1 1 1",
                                 frame_start_s, line_start_s, video_on_s);
                    end
                end
                209: begin
                    n_cmp++;
                    if (frame_start_s !== 1'b0 || line_start_s !== 1'b0) begin
                        n_err++;
                        $display("FAIL frame_pulse_width: fs=%b ls=%b want 0 0", frame_start_s, line_start_s);
                    end
                end
                default: ;
            endcase
        end
        n_cmp++;
        if (vs_low != 32) begin
            n_err++;
            $display("FAIL frame_vsync_span: %0d strobes low want 32", vs_low);
        end
        n_cmp++;
        if (fs_cnt != 2 || period != 208) begin
            n_err++;
            $display("FAIL frame_period: pulses=%0d period=%0d want 2 208", fs_cnt, period);
        end
        @(negedge clk);
        pix_en_s = 1'b0;
    endtask

    task automatic test_mid_frame_reset;
        do_reset();
        for (int k = 0; k < 40 * 800 + 123; k++) step(1'b1);
        n_cmp++;
        if (hc !== 10'd123 || vc !== 10'd40 || video_on !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_entry: hc=%0d vc=%0d von=%b want 123 40 1", hc, vc, video_on);
        end
        #2;
        clr = 1'b1;
        #1;
        n_cmp++;
        if (hc !== 10'd0 || vc !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 ||
            video_on !== 1'b1 || line_start !== 1'b0 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_async: hc=%0d vc=%0d hs=%b vs=%b von=%b ls=%b fs=%b want 0 0 1 1 1 0 0",
                     hc, vc, hsync, vsync, video_on, line_start, frame_start);
        end
        @(negedge clk);
        pix_en = 1'b0;
        clr    = 1'b0;
        step(1'b1);
        n_cmp++;
        if (hc !== 10'd1 || vc !== 10'd0 || line_start !== 1'b0 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_release: hc=%0d vc=%0d ls=%b fs=%b want 1 0 0 0",
                     hc, vc, line_start, frame_start);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        clr      = 1'b1;
        pix_en   = 1'b0;
        pix_en_s = 1'b0;
        test_reset();
        test_line_timing();
        test_stall();
        test_back_to_back();
        test_frame();
        test_mid_frame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
